// File: rtl/adpll_network_sequencer.sv
// Start-up and lock sequencer for the 2x2 NetworkADPLL mesh.
//
// Brings the nodes up in stages (11, then 12/21, then 22) under acquisition
// gains. Once every enabled node holds a small phase error long enough, it
// switches to tracking gains and the selected weight mode. Loss of lock sends
// it to RELOCK. Staying too long in an acquiring state sends it to FAULT.
//
// Ports:
//   fpga_clk_i        system clock; all inputs are synchronous to it
//   reset_i           asynchronous, active-high reset
//   start_i           level: high runs the sequence, low returns to IDLE
//   uni_dir_i         final weight mode: 1 = unidirectional, 0 = bidirectional
//   error_xy_i        signed phase error of node xy
//   enable_o          node enables {22, 21, 12, 11}
//   kp_o, ki_o        loop gain selects broadcast to all nodes
//   bidir_o           1 = bidirectional weight table
//   locked_o          high in TRACK
//   fault_o           high in FAULT
//   state_o           current state, for debug
module adpll_network_sequencer #(
  parameter int unsigned PDET_WIDTH    = 8,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned LOCK_THRESH   = 4,
  parameter int unsigned UNLOCK_THRESH = 16,
  parameter int unsigned LOCK_COUNT    = 1024,
  parameter int unsigned UNLOCK_COUNT  = 64,
  parameter int unsigned TIMEOUT       = 60000,
  parameter logic [3:0]  KP_ACQ        = 4'd8,
  parameter logic [3:0]  KI_ACQ        = 4'd4,
  parameter logic [3:0]  KP_TRK        = 4'd4,
  parameter logic [3:0]  KI_TRK        = 4'd1
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  uni_dir_i,
  input  logic [PDET_WIDTH-1:0] error_11_i,
  input  logic [PDET_WIDTH-1:0] error_12_i,
  input  logic [PDET_WIDTH-1:0] error_21_i,
  input  logic [PDET_WIDTH-1:0] error_22_i,
  output logic [3:0]            enable_o,
  output logic [3:0]            kp_o,
  output logic [3:0]            ki_o,
  output logic                  bidir_o,
  output logic                  locked_o,
  output logic                  fault_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRoot   = 3'd1,
    StRow    = 3'd2,
    StAll    = 3'd3,
    StTrack  = 3'd4,
    StRelock = 3'd5,
    StFault  = 3'd6
  } state_e;

  localparam logic [PDET_WIDTH-1:0] LockThr     = PDET_WIDTH'(LOCK_THRESH);
  localparam logic [PDET_WIDTH-1:0] UnlockThr   = PDET_WIDTH'(UNLOCK_THRESH);
  localparam logic [CNT_WIDTH-1:0]  LockCnt     = CNT_WIDTH'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0]  UnlockCnt   = CNT_WIDTH'(UNLOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0]  TimeoutLast = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [PDET_WIDTH-1:0] ErrMin      = {1'b1, {(PDET_WIDTH-1){1'b0}}};
  localparam logic [PDET_WIDTH-1:0] ErrMax      = {1'b0, {(PDET_WIDTH-1){1'b1}}};

  state_e                         state_q, state_d;
  logic [3:0][PDET_WIDTH-1:0]     err_q;
  logic [3:0][PDET_WIDTH-1:0]     mag;
  logic [3:0]                     in_lock, out_lock, watch;
  logic                           lock_qual, unlock_qual, acquiring;
  logic                           lock_done, unlock_done, timeout_done;
  logic [CNT_WIDTH-1:0]           lock_cnt_q, lock_cnt_d;
  logic [CNT_WIDTH-1:0]           unlock_cnt_q, unlock_cnt_d;
  logic [CNT_WIDTH-1:0]           tmo_cnt_q, tmo_cnt_d;
  logic [3:0]                     en_q, en_d, kp_q, kp_d, ki_q, ki_d;
  logic                           bidir_q, bidir_d, locked_q, locked_d, fault_q, fault_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Magnitude of each registered error; the most negative code saturates.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (!err_q[i][PDET_WIDTH-1]) begin
        mag[i] = err_q[i];
      end else if (err_q[i] == ErrMin) begin
        mag[i] = ErrMax;
      end else begin
        mag[i] = -err_q[i];
      end
      in_lock[i]  = (mag[i] <= LockThr);
      out_lock[i] = (mag[i] > UnlockThr);
    end
  end

  always_comb begin
    watch     = 4'b0000;
    acquiring = 1'b0;
    unique case (state_q)
      StRoot:   begin watch = 4'b0001; acquiring = 1'b1; end
      StRow:    begin watch = 4'b0111; acquiring = 1'b1; end
      StAll:    begin watch = 4'b1111; acquiring = 1'b1; end
      StRelock: begin watch = 4'b1111; acquiring = 1'b1; end
      StTrack:  watch = 4'b1111;
      default:  watch = 4'b0000;
    endcase
  end

  assign lock_qual    = (watch != 4'b0000) && ((in_lock & watch) == watch);
  assign unlock_qual  = |(out_lock & watch);
  assign lock_done    = (lock_cnt_q >= LockCnt);
  assign unlock_done  = (unlock_cnt_q >= UnlockCnt);
  assign timeout_done = (tmo_cnt_q >= TimeoutLast);

  // Next state; lock is tested before timeout so it wins a tie.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = StRoot;
      StRoot:   if (lock_done) state_d = StRow;   else if (timeout_done) state_d = StFault;
      StRow:    if (lock_done) state_d = StAll;   else if (timeout_done) state_d = StFault;
      StAll:    if (lock_done) state_d = StTrack; else if (timeout_done) state_d = StFault;
      StRelock: if (lock_done) state_d = StTrack; else if (timeout_done) state_d = StFault;
      StTrack:  if (unlock_done) state_d = StRelock;
      StFault:  state_d = StFault;
      default:  state_d = StIdle;
    endcase
    if (!start_i) state_d = StIdle;
  end

  // All counters restart whenever the state changes.
  always_comb begin
    lock_cnt_d   = '0;
    unlock_cnt_d = '0;
    tmo_cnt_d    = '0;
    if (state_d == state_q) begin
      if (lock_qual)                          lock_cnt_d   = sat_inc(lock_cnt_q);
      if (unlock_qual && state_q == StTrack)  unlock_cnt_d = sat_inc(unlock_cnt_q);
      if (acquiring)                          tmo_cnt_d    = sat_inc(tmo_cnt_q);
    end
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    en_d     = 4'b0000;
    kp_d     = KP_ACQ;
    ki_d     = KI_ACQ;
    bidir_d  = 1'b0;
    locked_d = 1'b0;
    fault_d  = 1'b0;
    unique case (state_d)
      StRoot:   en_d = 4'b0001;
      StRow:    en_d = 4'b0111;
      StAll:    en_d = 4'b1111;
      StRelock: en_d = 4'b1111;
      StTrack: begin
        en_d     = 4'b1111;
        kp_d     = KP_TRK;
        ki_d     = KI_TRK;
        bidir_d  = ~uni_dir_i;
        locked_d = 1'b1;
      end
      StFault:  fault_d = 1'b1;
      default:  en_d = 4'b0000;
    endcase
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      err_q        <= '0;
      lock_cnt_q   <= '0;
      unlock_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      en_q         <= 4'b0000;
      kp_q         <= KP_ACQ;
      ki_q         <= KI_ACQ;
      bidir_q      <= 1'b0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= {error_22_i, error_21_i, error_12_i, error_11_i};
      lock_cnt_q   <= lock_cnt_d;
      unlock_cnt_q <= unlock_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      en_q         <= en_d;
      kp_q         <= kp_d;
      ki_q         <= ki_d;
      bidir_q      <= bidir_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
    end
  end

  assign enable_o = en_q;
  assign kp_o     = kp_q;
  assign ki_o     = ki_q;
  assign bidir_o  = bidir_q;
  assign locked_o = locked_q;
  assign fault_o  = fault_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_adpll_network_sequencer.sv
// Bench for adpll_network_sequencer: a table of directed phases with
// hand-computed expectations, two hand-written multi-cycle sequences, then a
// randomized run compared against a cycle-level reference model.
module tb_adpll_network_sequencer;

  localparam int LockCount   = 8;
  localparam int UnlockCount = 4;
  localparam int Timeout     = 100;
  localparam int LockThr     = 4;
  localparam int UnlockThr   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       uni = 1'b1;
  logic [7:0] e [4];
  logic [3:0] enable, kp, ki;
  logic       bidir, locked, fault;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  adpll_network_sequencer #(
    .PDET_WIDTH   (8),
    .CNT_WIDTH    (16),
    .LOCK_THRESH  (LockThr),
    .UNLOCK_THRESH(UnlockThr),
    .LOCK_COUNT   (LockCount),
    .UNLOCK_COUNT (UnlockCount),
    .TIMEOUT      (Timeout)
  ) dut (
    .fpga_clk_i(clk),
    .reset_i   (rst),
    .start_i   (start),
    .uni_dir_i (uni),
    .error_11_i(e[0]),
    .error_12_i(e[1]),
    .error_21_i(e[2]),
    .error_22_i(e[3]),
    .enable_o  (enable),
    .kp_o      (kp),
    .ki_o      (ki),
    .bidir_o   (bidir),
    .locked_o  (locked),
    .fault_o   (fault),
    .state_o   (state)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {state, enable, kp, ki, bidir, locked, fault}.
  function automatic logic [17:0] pk(int st, logic [3:0] en, int kpv, int kiv,
                                     bit b, bit l, bit f);
    return {3'(st), en, 4'(kpv), 4'(kiv), b, l, f};
  endfunction

  function automatic string fmt(logic [17:0] v);
    return $sformatf("state=%0d en=%b kp=%0d ki=%0d bidir=%b locked=%b fault=%b",
                     v[17:15], v[14:11], v[10:7], v[6:3], v[2], v[1], v[0]);
  endfunction

  task automatic check(input string name, input logic [17:0] exp);
    logic [17:0] act;
    act = {state, enable, kp, ki, bidir, locked, fault};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got [%s] expected [%s]", name, fmt(act), fmt(exp));
    end
  endtask

  // Reference model: states 0..6 as named in the state_o encoding.
  int         m_state, m_run, m_urun, m_age;
  bit         m_bidir;
  logic [7:0] m_err [4];

  function automatic int mag(logic [7:0] v);
    int x;
    x = int'($signed(v));
    if (x < 0) x = -x;
    if (x > 127) x = 127;
    return x;
  endfunction

  function automatic bit watched(int st, int n);
    case (st)
      1:       return n == 0;
      2:       return n != 3;
      3, 4, 5: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_run = 0; m_urun = 0; m_age = 0; m_bidir = 1'b0;
    for (int n = 0; n < 4; n++) m_err[n] = 8'h00;
  endtask

  // One clock edge: m_run = consecutive all-quiet samples counted since entry,
  // m_urun = consecutive any-noisy samples in TRACK, m_age = edges since entry.
  task automatic model_step();
    int nxt;
    bit all_ok, any_bad, has_watch;
    has_watch = 1'b0; all_ok = 1'b1; any_bad = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (watched(m_state, n)) begin
        has_watch = 1'b1;
        if (mag(m_err[n]) > LockThr)   all_ok  = 1'b0;
        if (mag(m_err[n]) > UnlockThr) any_bad = 1'b1;
      end
    end
    all_ok = all_ok && has_watch;
    nxt = m_state;
    if (m_state == 0) begin
      nxt = 1;
    end else if (m_state == 1 || m_state == 2 || m_state == 3 || m_state == 5) begin
      if (m_run >= LockCount) nxt = (m_state == 1) ? 2 : (m_state == 2) ? 3 : 4;
      else if (m_age + 1 >= Timeout) nxt = 6;
    end else if (m_state == 4) begin
      if (m_urun >= UnlockCount) nxt = 5;
    end
    if (!start) nxt = 0;
    if (nxt != m_state) begin
      m_run = 0; m_urun = 0; m_age = 0;
    end else begin
      m_run  = all_ok ? m_run + 1 : 0;
      m_urun = (m_state == 4 && any_bad) ? m_urun + 1 : 0;
      m_age  = m_age + 1;
    end
    m_bidir = (nxt == 4) && !uni;
    for (int n = 0; n < 4; n++) m_err[n] = e[n];
    m_state = nxt;
  endtask

  function automatic logic [17:0] model_exp();
    logic [3:0] en;
    case (m_state)
      1:       en = 4'b0001;
      2:       en = 4'b0111;
      3, 4, 5: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return pk(m_state, en, (m_state == 4) ? 4 : 8, (m_state == 4) ? 1 : 4,
              m_bidir, m_state == 4, m_state == 6);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_err(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; uni = 1'b1;
    set_err(8'h00, 8'h00, 8'h00, 8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        start;
    logic        uni;
    logic [7:0]  e11, e12, e21, e22;
    int          edges;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic u, logic [7:0] a, logic [7:0] b,
                              logic [7:0] c, logic [7:0] d, int n, logic [17:0] x);
    vec_t v;
    v.start = s; v.uni = u; v.e11 = a; v.e12 = b; v.e21 = c; v.e22 = d;
    v.edges = n; v.exp = x;
    return v;
  endfunction

  initial begin
    logic [17:0] idle_x, track_x, relock_x;
    int regime, v;
    idle_x   = pk(0, 4'b0000, 8, 4, 0, 0, 0);
    track_x  = pk(4, 4'b1111, 4, 1, 0, 1, 0);
    relock_x = pk(5, 4'b1111, 8, 4, 0, 0, 0);

    // Nominal bring-up with errors of 2.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, idle_x));
    tbl.push_back(mk(1, 1, 2, 2, 2, 2, 1, pk(1, 4'b0001, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 2, 2, 2, 2, 8, pk(1, 4'b0001, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 2, 2, 2, 2, 1, pk(2, 4'b0111, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 2, 2, 2, 2, 8, pk(2, 4'b0111, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 2, 2, 2, 2, 1, pk(3, 4'b1111, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 2, 2, 2, 2, 8, pk(3, 4'b1111, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 2, 2, 2, 2, 1, track_x));
    // -128 on node 22 for 4 cycles: saturates to 127, unlock 5 edges later.
    tbl.push_back(mk(1, 1, 2, 2, 2, 8'h80, 4, track_x));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, track_x));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, relock_x));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8, relock_x));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, track_x));
    // |-16| sits on the unlock threshold and must not unlock.
    tbl.push_back(mk(1, 1, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 10, track_x));
    // Weight mode follows uni_dir one edge later.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, pk(4, 4'b1111, 4, 1, 1, 1, 0)));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, track_x));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, idle_x));
    // Timeout in ROW with node 12 held at 20.
    tbl.push_back(mk(1, 1, 0, 20, 0, 0, 1, pk(1, 4'b0001, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 0, 20, 0, 0, 8, pk(1, 4'b0001, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 0, 20, 0, 0, 1, pk(2, 4'b0111, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 0, 20, 0, 0, 99, pk(2, 4'b0111, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 0, 20, 0, 0, 1, pk(6, 4'b0000, 8, 4, 0, 0, 1)));
    tbl.push_back(mk(1, 1, 0, 20, 0, 0, 5, pk(6, 4'b0000, 8, 4, 0, 0, 1)));
    tbl.push_back(mk(0, 1, 0, 20, 0, 0, 1, idle_x));
    // Errors of +-4 sit on the lock threshold; start dropped mid-ALL.
    tbl.push_back(mk(1, 1, 4, 8'hFC, 4, 8'hFC, 1, pk(1, 4'b0001, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 4, 8'hFC, 4, 8'hFC, 9, pk(2, 4'b0111, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 4, 8'hFC, 4, 8'hFC, 9, pk(3, 4'b1111, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 4, 8'hFC, 4, 8'hFC, 3, pk(3, 4'b1111, 8, 4, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 4, 8'hFC, 4, 8'hFC, 1, idle_x));

    do_reset();
    check("reset", idle_x);

    foreach (tbl[i]) begin
      start = tbl[i].start;
      uni   = tbl[i].uni;
      set_err(tbl[i].e11, tbl[i].e12, tbl[i].e21, tbl[i].e22);
      repeat (tbl[i].edges) tick();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Interrupted qualification in ROOT: one sample of 5 restarts the count.
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      set_err((c == 8) ? 8'd5 : 8'd3, 8'd50, 8'd50, 8'd50);
      tick();
      if (c == 10) check("intr_no_early", pk(1, 4'b0001, 8, 4, 0, 0, 0));
      if (c == 17) check("intr_hold", pk(1, 4'b0001, 8, 4, 0, 0, 0));
      if (c == 18) check("intr_advance", pk(2, 4'b0111, 8, 4, 0, 0, 0));
    end

    // Asynchronous reset between edges while in TRACK.
    do_reset();
    start = 1'b1;
    repeat (28) tick();
    check("pre_reset_track", track_x);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", idle_x);
    do_reset();

    // Randomized run against the model.
    start = 1'b1;
    regime = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 60 == 0) regime = int'($urandom_range(5));
      for (int n = 0; n < 4; n++) begin
        case (regime)
          0, 1, 2: v = int'($urandom_range(8)) - 4;
          3:       v = int'($urandom_range(12)) - 6;
          4:       v = int'($urandom_range(255)) - 128;
          default: v = (n == 3) ? (($urandom_range(1) == 1) ? -128 : 17 + int'($urandom_range(20)))
                                : int'($urandom_range(6)) - 3;
        endcase
        e[n] = 8'(v);
      end
      start = ($urandom_range(299) != 0);
      if ($urandom_range(19) == 0) uni = ~uni;
      tick();
      check("random", model_exp());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
